// File: rtl/sprite_throw_ctl.sv
// -----------------------------------------------------------------------------
// sprite_throw_ctl
//
// Frame-synchronous trajectory controller for the 64x64 sprite draw stage.
// Game logic issues a throw (start point plus initial velocity). The block
// then moves the sprite once per frame under gravity until it reaches the
// ground line or a horizontal screen edge. xpos/ypos only change on the
// first cycle of vertical blanking, so the draw stage never sees a position
// change in the middle of a frame.
//
// Ports:
//   clk    in   1   pixel clock
//   rst    in   1   synchronous active-high reset
//   vblnk  in   1   vertical blank from the timing chain
//   start  in   1   throw request, single-cycle pulse (honoured in IDLE only)
//   x0     in  12   start x, unsigned
//   y0     in  12   start y, unsigned
//   vx0    in   8   initial horizontal velocity, signed px/frame
//   vy0    in   8   initial vertical velocity, signed px/frame (negative = up)
//   xpos   out 12   sprite x to the draw stage
//   ypos   out 12   sprite y to the draw stage
//   busy   out  1   high while in ARM or FLIGHT
//   done   out  1   one-cycle pulse after landing
//
// Build option:
//   THROW_BOUNCE_EN  when defined, a horizontal wall hit clamps xpos, reverses
//                    vx and the flight continues; only the ground ends it.
//                    When undefined, a wall hit ends the flight.
// -----------------------------------------------------------------------------
module sprite_throw_ctl #(
  parameter int SCREEN_W = 800,
  parameter int SCREEN_H = 600,
  parameter int SPR_W    = 64,
  parameter int SPR_H    = 64,
  parameter int GROUND_Y = SCREEN_H - SPR_H,
  parameter int GRAVITY  = 1,
  parameter int VY_MAX   = 63,
  parameter int X_REST   = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        start,
  input  logic [11:0] x0,
  input  logic [11:0] y0,
  input  logic [7:0]  vx0,
  input  logic [7:0]  vy0,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        busy,
  output logic        done
);

  // Unsigned limits for the 12-bit position registers.
  localparam logic [11:0] X_MAX_U  = 12'(SCREEN_W - SPR_W);
  localparam logic [11:0] GROUND_U = 12'(GROUND_Y);
  localparam logic [11:0] X_REST_U = 12'(X_REST);

  // Signed limits for the 13-bit trajectory arithmetic.
  localparam logic signed [12:0] X_MAX_S  = 13'(SCREEN_W - SPR_W);
  localparam logic signed [12:0] GROUND_S = 13'(GROUND_Y);
  localparam logic signed [12:0] GRAV_S   = 13'(GRAVITY);
  localparam logic signed [12:0] VY_HI_S  = 13'(VY_MAX);
  localparam logic signed [12:0] VY_LO_S  = -VY_HI_S;

`ifdef THROW_BOUNCE_EN
  localparam logic BOUNCE_EN = 1'b1;
`else
  localparam logic BOUNCE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARM    = 2'd1,
    S_FLIGHT = 2'd2,
    S_LAND   = 2'd3
  } state_t;

  state_t state_r;
  state_t state_nx_s;

  logic              vblnk_q_r;
  logic              tick_s;
  logic [11:0]       x0_r;
  logic [11:0]       y0_r;
  logic signed [12:0] vx_r;
  logic signed [12:0] vy_r;

  logic signed [12:0] xn_s;
  logic signed [12:0] yn_s;
  logic signed [12:0] vy_step_s;
  logic signed [12:0] vy0_ext_s;
  logic              ground_s;
  logic              wall_lo_s;
  logic              wall_hi_s;
  logic              wall_s;
  logic              y_neg_s;
  logic [11:0]       x_clamp_s;
  logic [11:0]       y_air_s;
  logic [11:0]       x0_clamp_s;
  logic [11:0]       y0_clamp_s;

  // Clamp a signed vertical velocity into +/-VY_MAX.
  function automatic logic signed [12:0] sat_vy(input logic signed [12:0] v);
    logic signed [12:0] r;
    if (v > VY_HI_S) begin
      r = VY_HI_S;
    end else if (v < VY_LO_S) begin
      r = VY_LO_S;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Frame tick: rising edge of vblnk, one cycle per frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q_r <= 1'b0;
    end else begin
      vblnk_q_r <= vblnk;
    end
  end

  assign tick_s = vblnk & ~vblnk_q_r;

  // Next-position arithmetic and edge detection for the FLIGHT state.
  always_comb begin
    xn_s      = $signed({1'b0, xpos}) + vx_r;
    yn_s      = $signed({1'b0, ypos}) + vy_r;
    vy_step_s = sat_vy(vy_r + GRAV_S);
    vy0_ext_s = sat_vy($signed({{5{vy0[7]}}, vy0}));
    ground_s  = (yn_s >= GROUND_S);
    wall_lo_s = (xn_s < 13'sd0);
    wall_hi_s = (xn_s > X_MAX_S);
    wall_s    = wall_lo_s | wall_hi_s;
    y_neg_s   = (yn_s < 13'sd0);
  end

  // Clamped coordinates: flight candidates and the ARM load values.
  always_comb begin
    if (wall_lo_s) begin
      x_clamp_s = 12'd0;
    end else if (wall_hi_s) begin
      x_clamp_s = X_MAX_U;
    end else begin
      x_clamp_s = xn_s[11:0];
    end

    if (y_neg_s) begin
      y_air_s = 12'd0;
    end else begin
      y_air_s = yn_s[11:0];
    end

    if (x0_r > X_MAX_U) begin
      x0_clamp_s = X_MAX_U;
    end else begin
      x0_clamp_s = x0_r;
    end

    if (y0_r > GROUND_U) begin
      y0_clamp_s = GROUND_U;
    end else begin
      y0_clamp_s = y0_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nx_s = S_ARM;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_ARM: begin
        if (tick_s) begin
          state_nx_s = S_FLIGHT;
        end else begin
          state_nx_s = S_ARM;
        end
      end
      S_FLIGHT: begin
        // With bouncing enabled a wall hit alone never ends the flight.
        if (tick_s && (ground_s || (wall_s && !BOUNCE_EN))) begin
          state_nx_s = S_LAND;
        end else begin
          state_nx_s = S_FLIGHT;
        end
      end
      S_LAND: begin
        state_nx_s = S_IDLE;
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // FSM outputs, decoded from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_r)
      S_IDLE: begin
        busy = 1'b0;
        done = 1'b0;
      end
      S_ARM, S_FLIGHT: begin
        busy = 1'b1;
        done = 1'b0;
      end
      S_LAND: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Throw capture, velocity state and frame-aligned position registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      xpos <= X_REST_U;
      ypos <= GROUND_U;
      x0_r <= 12'd0;
      y0_r <= 12'd0;
      vx_r <= 13'sd0;
      vy_r <= 13'sd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          // Capture wins over a coincident tick; the load waits for ARM.
          if (start) begin
            x0_r <= x0;
            y0_r <= y0;
            vx_r <= $signed({{5{vx0[7]}}, vx0});
            vy_r <= vy0_ext_s;
          end
        end
        S_ARM: begin
          if (tick_s) begin
            xpos <= x0_clamp_s;
            ypos <= y0_clamp_s;
          end
        end
        S_FLIGHT: begin
          if (tick_s) begin
            xpos <= x_clamp_s;
            if (ground_s) begin
              ypos <= GROUND_U;
            end else begin
              ypos <= y_air_s;
            end
            // Hitting the top edge kills the upward velocity.
            if (y_neg_s) begin
              vy_r <= 13'sd0;
            end else begin
              vy_r <= vy_step_s;
            end
            if (BOUNCE_EN && wall_s && !ground_s) begin
              vx_r <= -vx_r;
            end
          end
        end
        S_LAND: begin
          xpos <= xpos;
          ypos <= ypos;
        end
        default: begin
          xpos <= xpos;
          ypos <= ypos;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_throw_ctl.sv
module tb_sprite_throw_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vblnk = 1'b0;
  logic        start = 1'b0;
  logic [11:0] x0 = 12'd0;
  logic [11:0] y0 = 12'd0;
  logic [7:0]  vx0 = 8'd0;
  logic [7:0]  vy0 = 8'd0;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        busy;
  logic        done;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string       tag;
    logic [11:0] x;
    logic [11:0] y;
    logic        b;
    logic        d;
  } exp_t;

  exp_t sb[$];

  sprite_throw_ctl dut (
    .clk   (clk),
    .rst   (rst),
    .vblnk (vblnk),
    .start (start),
    .x0    (x0),
    .y0    (y0),
    .vx0   (vx0),
    .vy0   (vy0),
    .xpos  (xpos),
    .ypos  (ypos),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic sb_push(input string tag, input int x, input int y, input logic b, input logic d);
    exp_t e;
    e.tag = tag;
    e.x = 12'(x);
    e.y = 12'(y);
    e.b = b;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    compared++;
    assert (sb.size() > 0) else begin
      mismatched++;
      $error("FAIL sb_empty: observed 0 entries expected at least 1");
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".x"}, 32'(xpos), 32'(e.x));
      chk({e.tag, ".y"}, 32'(ypos), 32'(e.y));
      chk({e.tag, ".busy"}, 32'(busy), 32'(e.b));
      chk({e.tag, ".done"}, 32'(done), 32'(e.d));
    end
  endtask

  task automatic throw_req(input int x, input int y, input int vx, input int vy);
    x0 = 12'(x);
    y0 = 12'(y);
    vx0 = 8'(vx);
    vy0 = 8'(vy);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Raise vblnk; sample after the tick edge.
  task automatic frame();
    vblnk = 1'b1;
    @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (3) @(negedge clk);
    vblnk = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    @(negedge clk);
    sb_push(tag, 100, 536, 1'b0, 1'b0);
    sb_check();
    rst = 1'b0;
    @(negedge clk);
    sb_push({tag, "_after"}, 100, 536, 1'b0, 1'b0);
    sb_check();
  endtask

  initial begin
    int ey;
    int ev;

    // Reset
    repeat (2) @(negedge clk);
    sb_push("reset", 100, 536, 1'b0, 1'b0);
    sb_check();
    rst = 1'b0;
    @(negedge clk);

    // Basic arc
    throw_req(100, 400, 5, -10);
    sb_push("arc_arm", 100, 536, 1'b1, 1'b0);
    sb_check();
    frame(); sb_push("arc_t1", 100, 400, 1'b1, 1'b0); sb_check(); frame_end();
    frame(); sb_push("arc_t2", 105, 390, 1'b1, 1'b0); sb_check(); frame_end();
    throw_req(10, 10, 1, 1);
    sb_push("arc_ign", 105, 390, 1'b1, 1'b0);
    sb_check();
    frame(); sb_push("arc_t3", 110, 381, 1'b1, 1'b0); sb_check(); frame_end();
    frame(); sb_push("arc_t4", 115, 373, 1'b1, 1'b0); sb_check(); frame_end();
    for (int i = 0; i < 40; i++) begin
      sb_push("hold", 115, 373, 1'b1, 1'b0);
      @(negedge clk);
      sb_check();
    end
    ey = 373;
    ev = -7;
    for (int n = 5; n <= 31; n++) begin
      ey = ey + ev;
      ev = ev + 1;
      frame();
      sb_push("arc_fly", 100 + 5 * (n - 1), ey, 1'b1, 1'b0);
      sb_check();
      frame_end();
    end
    frame(); sb_push("arc_land", 255, 536, 1'b0, 1'b1); sb_check();
    @(negedge clk); sb_push("arc_done1", 255, 536, 1'b0, 1'b0); sb_check();
    frame_end();

    // Ground clamp
    throw_req(50, 530, 0, 10);
    sb_push("gnd_arm", 255, 536, 1'b1, 1'b0); sb_check();
    frame(); sb_push("gnd_t1", 50, 530, 1'b1, 1'b0); sb_check(); frame_end();
    frame(); sb_push("gnd_t2", 50, 536, 1'b0, 1'b1); sb_check();
    @(negedge clk); sb_push("gnd_done1", 50, 536, 1'b0, 1'b0); sb_check();
    frame_end();

    // Initial vy saturation (-128 -> -63), then mid-flight reset
    throw_req(100, 500, 0, -128);
    frame(); sb_push("sat_t1", 100, 500, 1'b1, 1'b0); sb_check(); frame_end();
    frame(); sb_push("sat_t2", 100, 437, 1'b1, 1'b0); sb_check(); frame_end();
    reset_pulse("midrst");

    // Right wall
    throw_req(730, 300, 10, -5);
    frame(); sb_push("wallr_t1", 730, 300, 1'b1, 1'b0); sb_check(); frame_end();
`ifdef THROW_BOUNCE_EN
    frame(); sb_push("wallr_t2", 736, 295, 1'b1, 1'b0); sb_check(); frame_end();
    frame(); sb_push("wallr_t3", 726, 291, 1'b1, 1'b0); sb_check(); frame_end();
`else
    frame(); sb_push("wallr_t2", 736, 295, 1'b0, 1'b1); sb_check(); frame_end();
`endif
    reset_pulse("wallr_rst");

    // Left wall
    throw_req(2, 100, -5, 0);
    frame(); sb_push("walll_t1", 2, 100, 1'b1, 1'b0); sb_check(); frame_end();
`ifdef THROW_BOUNCE_EN
    frame(); sb_push("walll_t2", 0, 100, 1'b1, 1'b0); sb_check(); frame_end();
    frame(); sb_push("walll_t3", 5, 101, 1'b1, 1'b0); sb_check(); frame_end();
`else
    frame(); sb_push("walll_t2", 0, 100, 1'b0, 1'b1); sb_check(); frame_end();
`endif
    reset_pulse("walll_rst");

    // start coincident with tick in IDLE; start point also clamped
    x0 = 12'd900;
    y0 = 12'd700;
    vx0 = 8'd0;
    vy0 = 8'd0;
    start = 1'b1;
    vblnk = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sb_push("coin_arm", 100, 536, 1'b1, 1'b0); sb_check();
    frame_end();
    frame(); sb_push("coin_t1", 736, 536, 1'b1, 1'b0); sb_check(); frame_end();
    frame(); sb_push("coin_t2", 736, 536, 1'b0, 1'b1); sb_check(); frame_end();

    // Top edge: ypos clamps to 0 and vy is zeroed
    throw_req(300, 3, 0, -10);
    frame(); sb_push("top_t1", 300, 3, 1'b1, 1'b0); sb_check(); frame_end();
    frame(); sb_push("top_t2", 300, 0, 1'b1, 1'b0); sb_check(); frame_end();
    frame(); sb_push("top_t3", 300, 0, 1'b1, 1'b0); sb_check(); frame_end();
    frame(); sb_push("top_t4", 300, 1, 1'b1, 1'b0); sb_check(); frame_end();
    reset_pulse("top_rst");

    compared++;
    assert (sb.size() == 0) else begin
      mismatched++;
      $error("FAIL sb_left: observed %0d entries expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
